// File: rtl/cpu16_bus_pkg.sv
// Shared CPU16 bus definitions: address map, region/state encodings, IO command payload.
package cpu16_bus_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned MEM_AW = 15;
   localparam int unsigned IO_AW  = 12;
   localparam int unsigned CNT_W  = 4;

   localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0000;
   localparam logic [ADDR_W-1:0] ROM_BASE = 16'h8000;
   localparam logic [ADDR_W-1:0] IO_BASE  = 16'hF000;

   localparam logic [DATA_W-1:0] IO_ABORT_DATA = 16'hFFFF;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_ROM,
      REG_IO
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROM_WAIT,
      ST_IO_REQ,
      ST_IO_DONE
   } state_e;

   typedef struct packed {
      logic [IO_AW-1:0]  addr;
      logic [DATA_W-1:0] wdata;
      logic              we;
   } io_cmd_t;

endpackage

// File: rtl/cpu16_mem_ctrl_if.sv
// CPU-side bus of the CPU16 memory controller.
interface cpu16_mem_ctrl_if;
   import cpu16_bus_pkg::*;

   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_data_out;
   logic              cpu_write;
   logic [DATA_W-1:0] cpu_data_in;
   logic              cpu_hold;

   modport master (
      output cpu_address, cpu_data_out, cpu_write,
      input  cpu_data_in, cpu_hold
   );

   modport slave (
      input  cpu_address, cpu_data_out, cpu_write,
      output cpu_data_in, cpu_hold
   );

endinterface

// File: rtl/cpu16_addr_decode.sv
// Combinational CPU16 address-to-region decode.
module cpu16_addr_decode
   import cpu16_bus_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   output region_e           region_c
);

   always_comb begin
      region_c = REG_RAM;
      if (addr >= IO_BASE) begin
         region_c = REG_IO;
      end else if (addr >= ROM_BASE) begin
         region_c = REG_ROM;
      end
   end

endmodule

// File: rtl/cpu16_mem_ctrl.sv
// CPU16 memory/bus controller: RAM/ROM/IO decode, ROM wait states, IO handshake.
// Optional IO timeout abort enabled by defining IO_TIMEOUT_EN.
module cpu16_mem_ctrl
   import cpu16_bus_pkg::*;
#(
   parameter int unsigned ROM_WAIT = 1
`ifdef IO_TIMEOUT_EN
   ,
   parameter int unsigned IO_TIMEOUT = 255
`endif
)(
   input  logic              clk,
   input  logic              reset,
   cpu16_mem_ctrl_if.slave   cpu,
   output logic [MEM_AW-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [MEM_AW-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_rdata,
   output logic [IO_AW-1:0]  io_addr,
   output logic [DATA_W-1:0] io_wdata,
   output logic              io_we,
   output logic              io_req,
   input  logic              io_ack,
   input  logic [DATA_W-1:0] io_rdata,
   output logic              bus_err
);

   localparam logic [CNT_W-1:0] ROM_LOAD = (ROM_WAIT == 0) ? '0 : CNT_W'(ROM_WAIT - 1);

   state_e            state, next_state;
   region_e           region;
   logic [CNT_W-1:0]  rom_cnt, rom_cnt_nxt;
   io_cmd_t           io_cmd;
   logic [DATA_W-1:0] io_data;
   logic              hold_c;
   logic [DATA_W-1:0] data_in_c;
   logic              io_latch_c;
   logic              io_cap_c;
   logic              io_timeout_c;
   logic              to_expired_c;

   cpu16_addr_decode u_decode (
      .addr     (cpu.cpu_address),
      .region_c (region)
   );

   assign ram_addr  = MEM_AW'(cpu.cpu_address - RAM_BASE);
   assign ram_wdata = cpu.cpu_data_out;
   assign rom_addr  = MEM_AW'(cpu.cpu_address - ROM_BASE);
   assign io_addr   = io_cmd.addr;
   assign io_wdata  = io_cmd.wdata;
   assign io_we     = io_cmd.we;

   assign cpu.cpu_hold    = hold_c;
   assign cpu.cpu_data_in = data_in_c;

   // Next-state and bus-cycle outputs; reset low forces hold and write strobe off
   always_comb begin
      next_state   = state;
      rom_cnt_nxt  = rom_cnt;
      hold_c       = 1'b0;
      data_in_c    = ram_rdata;
      ram_we       = 1'b0;
      io_latch_c   = 1'b0;
      io_cap_c     = 1'b0;
      io_timeout_c = 1'b0;
      case (state)
         ST_IDLE: begin
            case (region)
               REG_RAM: begin
                  data_in_c = ram_rdata;
                  ram_we    = cpu.cpu_write;
               end
               REG_ROM: begin
                  data_in_c = rom_rdata;
                  if (!cpu.cpu_write && (ROM_WAIT != 0)) begin
                     hold_c      = 1'b1;
                     rom_cnt_nxt = ROM_LOAD;
                     next_state  = ST_ROM_WAIT;
                  end
               end
               REG_IO: begin
                  hold_c     = 1'b1;
                  io_latch_c = 1'b1;
                  next_state = ST_IO_REQ;
               end
               default: ;
            endcase
         end
         ST_ROM_WAIT: begin
            data_in_c = rom_rdata;
            if (rom_cnt != '0) begin
               hold_c      = 1'b1;
               rom_cnt_nxt = rom_cnt - 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_IO_REQ: begin
            hold_c    = 1'b1;
            data_in_c = io_data;
            if (io_ack) begin
               io_cap_c   = 1'b1;
               next_state = ST_IO_DONE;
            end else if (to_expired_c) begin
               io_timeout_c = 1'b1;
               next_state   = ST_IO_DONE;
            end
         end
         ST_IO_DONE: begin
            data_in_c  = io_data;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      if (!reset) begin
         hold_c = 1'b0;
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         rom_cnt <= '0;
         io_req  <= 1'b0;
         io_cmd  <= '0;
         io_data <= '0;
      end else begin
         state   <= next_state;
         rom_cnt <= rom_cnt_nxt;
         io_req  <= (next_state == ST_IO_REQ);
         if (io_latch_c) begin
            io_cmd <= '{addr:  IO_AW'(cpu.cpu_address - IO_BASE),
                        wdata: cpu.cpu_data_out,
                        we:    cpu.cpu_write};
         end
         // Write completions return zero to the CPU
         if (io_cap_c) begin
            io_data <= io_cmd.we ? '0 : io_rdata;
         end else if (io_timeout_c) begin
            io_data <= IO_ABORT_DATA;
         end
      end
   end

`ifdef IO_TIMEOUT_EN
   localparam int unsigned TO_W = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);

   logic [TO_W-1:0] to_cnt;
   logic            bus_err_q;

   assign to_expired_c = (to_cnt == TO_LAST);
   assign bus_err      = bus_err_q;

   // Timeout counter runs only while a request is outstanding; error is sticky
   always_ff @(posedge clk) begin
      if (!reset) begin
         to_cnt    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (state == ST_IO_REQ) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end
         if (io_timeout_c) begin
            bus_err_q <= 1'b1;
         end
      end
   end
`else
   assign to_expired_c = 1'b0;
   assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu16_mem_ctrl.sv
// Scoreboard bench for cpu16_mem_ctrl (ROM_WAIT=2 main instance, ROM_WAIT=0 side instance).
module tb_cpu16_mem_ctrl;
   import cpu16_bus_pkg::*;

   typedef struct {
      string       nm;
      logic [15:0] data;
      bit          chk_data;
      bit          we;
      int          holds;
   } exp_t;

   logic clk;
   logic reset;

   cpu16_mem_ctrl_if bus ();
   cpu16_mem_ctrl_if bus0 ();

   logic [14:0] ram_addr, rom_addr;
   logic [15:0] ram_wdata, ram_rdata, rom_rdata;
   logic        ram_we;
   logic [11:0] io_addr;
   logic [15:0] io_wdata, io_rdata;
   logic        io_we, io_req, io_ack, bus_err;
   logic        rsp_ack, spur_ack;

   logic [14:0] ram_addr0, rom_addr0;
   logic [15:0] ram_wdata0, rom_rdata0;
   logic        ram_we0, io_we0, io_req0, bus_err0;
   logic [11:0] io_addr0;
   logic [15:0] io_wdata0;

   region_e     mdec_region;
   logic [15:0] ram_mem [0:32767];

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   active   = 1'b0;
   int   holdcnt  = 0;

   bit          rsp_en = 1'b1;
   int          rsp_delay = 1;
   logic [15:0] rsp_data = '0;
   int          reqcyc = 0;
   int          req_seen = 0;
   logic [11:0] exp_io_addr = '0;
   logic        exp_io_we = 1'b0;
   logic [15:0] exp_io_wdata = '0;

   cpu16_mem_ctrl #(
      .ROM_WAIT   (2)
`ifdef IO_TIMEOUT_EN
      ,
      .IO_TIMEOUT (8)
`endif
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu       (bus.slave),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .rom_addr  (rom_addr),
      .rom_rdata (rom_rdata),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_we     (io_we),
      .io_req    (io_req),
      .io_ack    (io_ack),
      .io_rdata  (io_rdata),
      .bus_err   (bus_err)
   );

   cpu16_mem_ctrl #(
      .ROM_WAIT (0)
   ) u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .cpu       (bus0.slave),
      .ram_addr  (ram_addr0),
      .ram_wdata (ram_wdata0),
      .ram_we    (ram_we0),
      .ram_rdata (16'h0000),
      .rom_addr  (rom_addr0),
      .rom_rdata (rom_rdata0),
      .io_addr   (io_addr0),
      .io_wdata  (io_wdata0),
      .io_we     (io_we0),
      .io_req    (io_req0),
      .io_ack    (1'b0),
      .io_rdata  (16'h0000),
      .bus_err   (bus_err0)
   );

   cpu16_addr_decode u_mdec (
      .addr     (bus.cpu_address),
      .region_c (mdec_region)
   );

   function automatic logic [15:0] rom_word(input logic [14:0] a);
      return (a == 15'd0) ? 16'hD950 : (16'hA000 ^ {1'b0, a});
   endfunction

   assign ram_rdata  = ram_mem[ram_addr];
   assign rom_rdata  = rom_word(rom_addr);
   assign rom_rdata0 = rom_word(rom_addr0);
   assign io_ack     = rsp_ack | spur_ack;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (ram_we && (mdec_region == REG_RAM)) ram_mem[ram_addr] <= ram_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // IO device: acks after rsp_delay request cycles, checks the latched command
   always @(posedge clk) begin
      #1;
      rsp_ack = 1'b0;
      if (io_req && rsp_en) begin
         reqcyc++;
         if (reqcyc == rsp_delay) begin
            rsp_ack  = 1'b1;
            io_rdata = rsp_data;
            reqcyc   = 0;
         end
      end else begin
         reqcyc = 0;
      end
   end

   always @(negedge clk) begin
      if (io_req) begin
         req_seen++;
         chk("io_addr", 32'(io_addr), 32'(exp_io_addr));
         chk("io_we", 32'(io_we), 32'(exp_io_we));
         chk("io_wdata", 32'(io_wdata), 32'(exp_io_wdata));
      end
   end

   // Monitor: a non-held cycle of an active access completes it
   always @(negedge clk) begin
      if (active) begin
         if (bus.cpu_hold) begin
            holdcnt++;
         end else begin
            if (q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk({e.nm, "_holds"}, 32'(holdcnt), 32'(e.holds));
               chk({e.nm, "_we"}, 32'(ram_we), 32'(e.we));
               if (e.chk_data) chk({e.nm, "_data"}, 32'(bus.cpu_data_in), 32'(e.data));
            end
            holdcnt = 0;
         end
      end
   end

   task automatic access(input string nm, input logic [15:0] a, input logic [15:0] d,
                         input bit w, input bit cd, input logic [15:0] ed,
                         input bit ewe, input int eh);
      exp_t e;
      int   n;
      e = '{nm: nm, data: ed, chk_data: cd, we: ewe, holds: eh};
      q.push_back(e);
      bus.cpu_address  = a;
      bus.cpu_data_out = d;
      bus.cpu_write    = w;
      active = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.cpu_hold && n < 64);
      if (bus.cpu_hold) chk({nm, "_timeout"}, 32'd1, 32'd0);
      @(posedge clk);
      #1;
      active = 1'b0;
      bus.cpu_write = 1'b0;
   endtask

   task automatic io_expect(input logic [11:0] a, input bit w, input logic [15:0] d,
                            input int dly, input logic [15:0] rd);
      exp_io_addr  = a;
      exp_io_we    = w;
      exp_io_wdata = d;
      rsp_delay    = dly;
      rsp_data     = rd;
      req_seen     = 0;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) ram_mem[i] = 16'h0000;
      reset = 1'b0;
      spur_ack = 1'b0;
      rsp_ack = 1'b0;
      io_rdata = 16'h0000;
      bus.cpu_address  = 16'hF000;
      bus.cpu_data_out = 16'h0000;
      bus.cpu_write    = 1'b0;
      bus0.cpu_address  = 16'h0000;
      bus0.cpu_data_out = 16'h0000;
      bus0.cpu_write    = 1'b0;

      @(negedge clk);
      chk("rst_hold", 32'(bus.cpu_hold), 32'd0);
      chk("rst_io_req", 32'(io_req), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      bus.cpu_address = 16'h0000;
      @(posedge clk);
      #1 reset = 1'b1;

      access("ram_wr", 16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 0);
      access("ram_rd", 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 0);
      access("ram_top_wr", 16'h7FFF, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b1, 0);
      access("ram_top_rd", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b0, 0);
      access("rom_rd", 16'h8000, 16'h0000, 1'b0, 1'b1, 16'hD950, 1'b0, 2);
      access("ram_after_rom", 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 0);
      access("rom_top_rd", 16'hEFFF, 16'h0000, 1'b0, 1'b1, 16'hCFFF, 1'b0, 2);
      access("rom_wr", 16'h8004, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0, 0);

      io_expect(12'h004, 1'b0, 16'h0000, 4, 16'h4829);
      access("io_rd", 16'hF004, 16'h0000, 1'b0, 1'b1, 16'h4829, 1'b0, 5);
      chk("io_rd_req_len", 32'(req_seen), 32'd4);

      io_expect(12'h002, 1'b1, 16'hBEEF, 1, 16'h7777);
      access("io_wr", 16'hF002, 16'hBEEF, 1'b1, 1'b1, 16'h0000, 1'b0, 2);
      chk("io_wr_req_len", 32'(req_seen), 32'd1);

      spur_ack = 1'b1;
      access("spur_ack_ram", 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 0);
      spur_ack = 1'b0;
      chk("spur_io_req", 32'(io_req), 32'd0);

      io_expect(12'hFFF, 1'b0, 16'h0000, 2, 16'h1357);
      access("io_top_rd", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h1357, 1'b0, 3);

`ifdef IO_TIMEOUT_EN
      rsp_en = 1'b0;
      io_expect(12'h008, 1'b0, 16'h0000, 1, 16'h0000);
      access("io_timeout", 16'hF008, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 9);
      chk("timeout_req_len", 32'(req_seen), 32'd8);
      chk("bus_err_set", 32'(bus_err), 32'd1);
      access("ram_after_to", 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 0);
      chk("bus_err_sticky", 32'(bus_err), 32'd1);
      rsp_en = 1'b1;
`else
      chk("bus_err_tied", 32'(bus_err), 32'd0);
`endif

      // Reset while a request is outstanding
      rsp_en = 1'b0;
      io_expect(12'h010, 1'b0, 16'h0000, 1, 16'h0000);
      bus.cpu_address = 16'hF010;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort_io_req_before", 32'(io_req), 32'd1);
      reset = 1'b0;
      #3;
      chk("abort_hold_in_reset", 32'(bus.cpu_hold), 32'd0);
      @(posedge clk);
      #1;
      chk("abort_io_req_after", 32'(io_req), 32'd0);
      chk("abort_bus_err", 32'(bus_err), 32'd0);
      bus.cpu_address = 16'h0010;
      reset = 1'b1;
      rsp_en = 1'b1;
      access("ram_after_abort", 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 0);
      io_expect(12'h00A, 1'b0, 16'h0000, 1, 16'h0A0A);
      access("io_after_abort", 16'hF00A, 16'h0000, 1'b0, 1'b1, 16'h0A0A, 1'b0, 2);

      // Zero-wait ROM instance
      bus0.cpu_address = 16'h8000;
      @(negedge clk);
      chk("rom0_hold", 32'(bus0.cpu_hold), 32'd0);
      chk("rom0_data", 32'(bus0.cpu_data_in), 32'hD950);
      @(posedge clk);
      #1 bus0.cpu_address = 16'h8001;
      @(negedge clk);
      chk("rom0_next_hold", 32'(bus0.cpu_hold), 32'd0);
      chk("rom0_next_data", 32'(bus0.cpu_data_in), 32'hA001);

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         chk("scoreboard_leftover", 32'(q.size()), 32'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu16_mem_ctrl.md
Name: cpu16_mem_ctrl

Overview:
- Memory/bus controller sitting directly between the CPU16 core and the system memories.
- Decodes the CPU address into three regions, muxes read data onto the CPU data input and routes writes.
- Inserts wait states on ROM and handshakes slow IO devices by asserting the CPU hold input.
- Every CPU bus cycle passes through this block.

Parameters:
- ROM_WAIT, 1, ROM wait states per access (0..15); 0 means the access completes in the cycle it is presented.
- IO_TIMEOUT, 255, cycles to wait for io_ack before aborting (used only with IO_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- cpu_address  in  16  CPU address
- cpu_data_out  in  16  CPU write data
- cpu_write  in  1  1 = write cycle, 0 = read cycle
- cpu_data_in  out  16  read data to CPU
- cpu_hold  out  1  stall CPU; CPU keeps address/data/write stable while high
- ram_addr  out  15  RAM word address
- ram_wdata  out  16  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  16  RAM read data (asynchronous read)
- rom_addr  out  15  ROM word address
- rom_rdata  in  16  ROM read data (asynchronous read)
- io_addr  out  12  IO register address (latched)
- io_wdata  out  16  IO write data (latched)
- io_we  out  1  IO write qualifier, valid while io_req
- io_req  out  1  IO request, registered
- io_ack  in  1  IO completion, one-cycle pulse
- io_rdata  in  16  IO read data, valid with io_ack
- bus_err  out  1  sticky IO timeout flag

Behaviour:
- Address map:
  - RAM: 0x0000-0x7FFF, ram_addr = addr[14:0]
  - ROM: 0x8000-0xEFFF, rom_addr = addr[14:0]
  - IO: 0xF000-0xFFFF, io_addr = addr[11:0]
- FSM states: IDLE, ROM_WAIT, IO_REQ, IO_DONE.
- IDLE:
  - RAM: zero wait. cpu_hold = 0; cpu_data_in = ram_rdata combinationally; ram_we = cpu_write. Stay in IDLE.
  - ROM read:
    - ROM_WAIT = 0: complete like RAM.
    - Otherwise: cpu_hold = 1, load counter with ROM_WAIT-1, go to ROM_WAIT.
  - ROM write: discarded, completes in the same cycle, no hold, no strobe.
  - IO: cpu_hold = 1; latch addr/data/write; go to IO_REQ. io_req rises on the next edge.
- ROM_WAIT:
  - cpu_hold = 1 while counter != 0; counter decrements each cycle.
  - When counter = 0: cpu_hold = 0, cpu_data_in = rom_rdata, next state IDLE.
  - Total latency is ROM_WAIT+1 cycles including the presentation cycle.
- IO_REQ:
  - io_req = 1, cpu_hold = 1.
  - On io_ack: latch io_rdata (write: latch 0x0000), drop io_req on the same edge, go to IO_DONE.
- IO_DONE:
  - cpu_hold = 0; cpu_data_in = latched IO data; next state IDLE.
- Minimum IO latency is 3 cycles (present, req, done).
- io_ack outside IO_REQ is ignored.
- ram_we is never asserted outside an IDLE RAM write cycle.
- cpu_hold is combinational from state and decode. It must not depend on cpu_data_out.
- Reset:
  - State IDLE, io_req 0, counter 0, IO data latch 0x0000, bus_err 0.
  - cpu_hold is 0 while reset is low.
  - Reset during ROM_WAIT or IO_REQ aborts the access; io_req falls on that edge and no data is returned.
- Back-to-back accesses: a new access may start in the cycle immediately after any completing cycle.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- Defined:
  - A counter runs in IO_REQ. After IO_TIMEOUT cycles without io_ack: drop io_req, go to IO_DONE returning 0xFFFF, set bus_err.
  - bus_err stays set until reset.
  - io_ack arriving in the same cycle as the timeout wins (normal completion).
- Undefined:
  - IO_REQ waits indefinitely; bus_err is tied to 0; no timeout counter exists.

Decomposition:
- Shared package cpu16_bus_pkg holds:
  - the region base/limit constants (RAM_BASE, ROM_BASE, IO_BASE)
  - a region decode enum {REG_RAM, REG_ROM, REG_IO}
  - the FSM state encoding
  - the IO abort data constant 0xFFFF
- One natural sub-module: cpu16_addr_decode, purely combinational address-to-region decode. It is reused by the bench's memory model.

Test Plan:
- RAM read/write:
  - Write 0x1234 to 0x0010, then read 0x0010: ram_we pulses 1 cycle, cpu_hold stays 0, cpu_data_in = 0x1234 in the read cycle.
  - Same sequence with ROM_WAIT = 0: a read of 0x8000 returns rom_rdata with no hold.
- ROM read, ROM_WAIT = 2, read 0x8000 with rom_rdata 0xD950: cpu_hold high 2 cycles; data returned on the 3rd cycle; following RAM access unstalled.
- IO read 0xF004, bench acks after 4 cycles with 0x4829: io_addr = 0x004; io_req high from cycle 1 until the ack edge; cpu_data_in = 0x4829 in IO_DONE; hold low that cycle.
- IO write 0xF002 = 0xBEEF: io_we = 1 and io_wdata = 0xBEEF for the whole req; a spurious io_ack in IDLE has no effect.
- Reset low mid IO_REQ: io_req = 0 and cpu_hold = 0 after the edge; the next access decodes normally.
- IO_TIMEOUT_EN with IO_TIMEOUT = 8, no ack: io_req drops after 8 cycles, cpu_data_in = 0xFFFF, bus_err = 1 and held until reset.
